// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundle of the two requester ports and the RAM port
// of mem_port_arbiter.
//   m0_*  : instruction-fetch requester (read only)
//   m1_*  : load/store requester (read/write)
//   ram_* : single-port RAM access port
//   hold_flag_o : stall request towards the pipeline ctrl block
// Modports:
//   slave  - arbiter view (takes requests, drives grants/responses and RAM)
//   master - environment view (requesters plus RAM model)
interface mem_port_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 4
);
    logic             m0_req_i;
    logic [WIDTH-1:0] m0_addr_i;
    logic             m0_gnt_o;
    logic             m0_rvalid_o;
    logic [WIDTH-1:0] m0_rdata_o;

    logic             m1_req_i;
    logic             m1_we_i;
    logic [WIDTH-1:0] m1_addr_i;
    logic [WIDTH-1:0] m1_wdata_i;
    logic [SEL_W-1:0] m1_sel_i;
    logic             m1_gnt_o;
    logic             m1_rvalid_o;
    logic [WIDTH-1:0] m1_rdata_o;

    logic             ram_req_o;
    logic             ram_we_o;
    logic [WIDTH-1:0] ram_addr_o;
    logic [WIDTH-1:0] ram_wdata_o;
    logic [SEL_W-1:0] ram_sel_o;
    logic             ram_ready_i;
    logic [WIDTH-1:0] ram_rdata_i;

    logic             hold_flag_o;

    modport slave (
        input  m0_req_i, m0_addr_i,
        output m0_gnt_o, m0_rvalid_o, m0_rdata_o,
        input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_sel_i,
        output m1_gnt_o, m1_rvalid_o, m1_rdata_o,
        output ram_req_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_sel_o,
        input  ram_ready_i, ram_rdata_i,
        output hold_flag_o
    );

    modport master (
        output m0_req_i, m0_addr_i,
        input  m0_gnt_o, m0_rvalid_o, m0_rdata_o,
        output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_sel_i,
        input  m1_gnt_o, m1_rvalid_o, m1_rdata_o,
        input  ram_req_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_sel_o,
        output ram_ready_i, ram_rdata_i,
        input  hold_flag_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM between the instruction
// fetch path (master 0, read only) and the load/store path (master 1).
// One access is granted per cycle; read data returns one cycle after the
// grant and is steered to its owner via rvalid. hold_flag_o stalls the
// pipeline while a fetch request is waiting.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - mem_port_arbiter_if.slave (requesters, RAM port, hold flag)
// Build option:
//   ARB_ROUND_ROBIN_EN - when defined, contention is resolved round-robin
//   (master 0 wins the first contention); otherwise master 1 always wins.
module mem_port_arbiter #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 4
) (
    input logic                clk,
    input logic                rst,
    mem_port_arbiter_if.slave  bus
);

    typedef enum logic {IDLE, RESP} state_t;

    state_t state_q, state_d;
    logic   owner_q, owner_d;
    logic   winner;          // 1 = master 1, 0 = master 0
    logic   gnt0, gnt1;
    logic   rd_gnt;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_gnt_q;        // master granted most recently

    always_comb begin
        if (bus.m0_req_i && bus.m1_req_i) begin
            winner = ~last_gnt_q;
        end else begin
            winner = bus.m1_req_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_q <= 1'b1;
        end else if (gnt0 || gnt1) begin
            last_gnt_q <= gnt1;
        end
    end
`else
    always_comb begin
        winner = bus.m1_req_i;
    end
`endif

    // Grants are suppressed during reset so nothing is launched that the
    // reset response state would then lose.
    always_comb begin
        gnt0 = ~rst & bus.m0_req_i & ~winner & bus.ram_ready_i;
        gnt1 = ~rst & bus.m1_req_i &  winner & bus.ram_ready_i;
        rd_gnt = gnt0 | (gnt1 & ~bus.m1_we_i);
    end

    assign bus.m0_gnt_o    = gnt0;
    assign bus.m1_gnt_o    = gnt1;
    assign bus.ram_req_o   = gnt0 | gnt1;
    assign bus.hold_flag_o = ~rst & bus.m0_req_i & ~gnt0;

    always_comb begin
        bus.ram_we_o    = 1'b0;
        bus.ram_addr_o  = '0;
        bus.ram_wdata_o = '0;
        bus.ram_sel_o   = '0;
        if (gnt1) begin
            bus.ram_we_o    = bus.m1_we_i;
            bus.ram_addr_o  = bus.m1_addr_i;
            bus.ram_wdata_o = bus.m1_wdata_i;
            bus.ram_sel_o   = bus.m1_sel_i;
        end else if (gnt0) begin
            bus.ram_addr_o  = bus.m0_addr_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        owner_d = owner_q;
        case (state_q)
            IDLE: begin
                if (rd_gnt) begin
                    state_d = RESP;
                    owner_d = gnt1;
                end
            end
            RESP: begin
                // A read granted during the response cycle keeps the
                // pipeline full; otherwise the response simply ends.
                if (rd_gnt) begin
                    state_d = RESP;
                    owner_d = gnt1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.m0_rvalid_o = (state_q == RESP) & ~owner_q;
    assign bus.m1_rvalid_o = (state_q == RESP) &  owner_q;
    assign bus.m0_rdata_o  = bus.ram_rdata_i;
    assign bus.m1_rdata_o  = bus.ram_rdata_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.WIDTH(32), .SEL_W(4)) bus ();

    mem_port_arbiter #(.WIDTH(32), .SEL_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    bit run    = 1'b0;

    logic [31:0] mem [0:255];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // RAM model: 1-cycle read latency, byte-enabled writes.
    always @(posedge clk) begin
        if (bus.ram_req_o && bus.ram_ready_i) begin
            if (bus.ram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (bus.ram_sel_o[b])
                        mem[bus.ram_addr_o[9:2]][8*b +: 8] <= bus.ram_wdata_o[8*b +: 8];
            end else begin
                bus.ram_rdata_i <= mem[bus.ram_addr_o[9:2]];
            end
        end
    end

    // Behavioural model: who should win, what the RAM should see, and
    // which master owes a response next cycle with what data.
    int          pend   = -1;     // owner of the response due this cycle
    logic [31:0] pend_d = '0;
    int          last_w = 1;      // master granted most recently

    always @(negedge clk) begin
        if (run) begin
            int          w;
            logic        e_g0, e_g1, e_we;
            logic [31:0] e_addr, e_wdata;
            logic [3:0]  e_sel;
            w = -1;
            if (!rst && bus.ram_ready_i) begin
                if (bus.m0_req_i && bus.m1_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
                    w = (last_w == 1) ? 0 : 1;
`else
                    w = 1;
`endif
                end else if (bus.m1_req_i) w = 1;
                else if (bus.m0_req_i)     w = 0;
            end
            e_g0 = (w == 0);
            e_g1 = (w == 1);
            e_we    = e_g1 & bus.m1_we_i;
            e_addr  = e_g1 ? bus.m1_addr_i  : (e_g0 ? bus.m0_addr_i : 32'h0);
            e_wdata = e_g1 ? bus.m1_wdata_i : 32'h0;
            e_sel   = e_g1 ? bus.m1_sel_i   : 4'h0;

            chk("m0_gnt", {31'b0, bus.m0_gnt_o}, {31'b0, e_g0});
            chk("m1_gnt", {31'b0, bus.m1_gnt_o}, {31'b0, e_g1});
            chk("ram_req", {31'b0, bus.ram_req_o}, {31'b0, e_g0 | e_g1});
            chk("ram_we", {31'b0, bus.ram_we_o}, {31'b0, e_we});
            chk("ram_addr", bus.ram_addr_o, e_addr);
            chk("ram_wdata", bus.ram_wdata_o, e_wdata);
            chk("ram_sel", {28'b0, bus.ram_sel_o}, {28'b0, e_sel});
            chk("hold", {31'b0, bus.hold_flag_o}, {31'b0, !rst && bus.m0_req_i && !e_g0});
            chk("m0_rvalid", {31'b0, bus.m0_rvalid_o}, {31'b0, pend == 0});
            chk("m1_rvalid", {31'b0, bus.m1_rvalid_o}, {31'b0, pend == 1});
            if (pend == 0) chk("m0_rdata", bus.m0_rdata_o, pend_d);
            if (pend == 1) chk("m1_rdata", bus.m1_rdata_o, pend_d);

            if (rst) begin
                pend   = -1;
                last_w = 1;
            end else if (w >= 0) begin
                last_w = w;
                pend   = (e_g1 && bus.m1_we_i) ? -1 : w;
                pend_d = mem[e_addr[9:2]];
            end else begin
                pend = -1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.m0_req_i   = 1'b0;
        bus.m0_addr_i  = '0;
        bus.m1_req_i   = 1'b0;
        bus.m1_we_i    = 1'b0;
        bus.m1_addr_i  = '0;
        bus.m1_wdata_i = '0;
        bus.m1_sel_i   = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] rr_exp;
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
        mem[4] = 32'h0000_0013;
        idle_inputs();
        bus.ram_ready_i = 1'b1;
        bus.ram_rdata_i = '0;

        // Reset: a held fetch request gets no grant and raises no hold.
        rst = 1'b1;
        bus.m0_req_i  = 1'b1;
        bus.m0_addr_i = 32'h10;
        tick();
        run = 1'b1;
        @(negedge clk);
        chk("rst_gnt0", {31'b0, bus.m0_gnt_o}, 32'h0);
        chk("rst_hold", {31'b0, bus.hold_flag_o}, 32'h0);
        chk("rst_rvalid0", {31'b0, bus.m0_rvalid_o}, 32'h0);
        tick();
        rst = 1'b0;
        bus.m0_req_i = 1'b0;
        tick();

        // Single fetch at 0x10.
        bus.m0_req_i  = 1'b1;
        bus.m0_addr_i = 32'h10;
        @(negedge clk);
        chk("fetch_gnt", {31'b0, bus.m0_gnt_o}, 32'h1);
        tick();
        bus.m0_req_i = 1'b0;
        @(negedge clk);
        chk("fetch_rvalid", {31'b0, bus.m0_rvalid_o}, 32'h1);
        chk("fetch_rdata", bus.m0_rdata_o, 32'h0000_0013);
        chk("fetch_m1_rvalid", {31'b0, bus.m1_rvalid_o}, 32'h0);
        tick();

        // Contention: load at 0x100 vs fetch at 0x4.
        bus.m0_req_i  = 1'b1;
        bus.m0_addr_i = 32'h4;
        bus.m1_req_i  = 1'b1;
        bus.m1_addr_i = 32'h100;
        @(negedge clk);
        chk("cont_m1_gnt", {31'b0, bus.m1_gnt_o}, 32'h1);
        chk("cont_hold", {31'b0, bus.hold_flag_o}, 32'h1);
        tick();
        bus.m1_req_i = 1'b0;
        @(negedge clk);
        chk("cont_m0_gnt", {31'b0, bus.m0_gnt_o}, 32'h1);
        chk("cont_m1_rvalid", {31'b0, bus.m1_rvalid_o}, 32'h1);
        chk("cont_m1_rdata", bus.m1_rdata_o, 32'h1000_0040);
        tick();
        bus.m0_req_i = 1'b0;
        @(negedge clk);
        chk("cont_m0_rvalid", {31'b0, bus.m0_rvalid_o}, 32'h1);
        chk("cont_m0_rdata", bus.m0_rdata_o, 32'h1000_0001);
        tick();

        // Store 0xDEADBEEF, low half only, at 0x200; then read it back.
        bus.m1_req_i   = 1'b1;
        bus.m1_we_i    = 1'b1;
        bus.m1_addr_i  = 32'h200;
        bus.m1_wdata_i = 32'hDEAD_BEEF;
        bus.m1_sel_i   = 4'b0011;
        @(negedge clk);
        chk("st_we", {31'b0, bus.ram_we_o}, 32'h1);
        chk("st_addr", bus.ram_addr_o, 32'h200);
        chk("st_wdata", bus.ram_wdata_o, 32'hDEAD_BEEF);
        chk("st_sel", {28'b0, bus.ram_sel_o}, 32'h3);
        tick();
        idle_inputs();
        @(negedge clk);
        chk("st_no_rvalid", {30'b0, bus.m1_rvalid_o, bus.m0_rvalid_o}, 32'h0);
        tick();
        bus.m1_req_i  = 1'b1;
        bus.m1_addr_i = 32'h200;
        tick();
        bus.m1_req_i = 1'b0;
        @(negedge clk);
        chk("st_readback", bus.m1_rdata_o, 32'h1000_BEEF);
        tick();

        // Back-to-back fetches 0x0, 0x4, 0x8.
        bus.m0_req_i  = 1'b1;
        bus.m0_addr_i = 32'h0;
        tick();
        bus.m0_addr_i = 32'h4;
        @(negedge clk);
        chk("b2b_rdata0", bus.m0_rdata_o, 32'h1000_0000);
        tick();
        bus.m0_addr_i = 32'h8;
        @(negedge clk);
        chk("b2b_rdata1", bus.m0_rdata_o, 32'h1000_0001);
        tick();
        bus.m0_req_i = 1'b0;
        @(negedge clk);
        chk("b2b_rvalid2", {31'b0, bus.m0_rvalid_o}, 32'h1);
        chk("b2b_rdata2", bus.m0_rdata_o, 32'h1000_0002);
        tick();

        // Backpressure: three stalled cycles, then grant; the response
        // still completes while ready is low again.
        bus.ram_ready_i = 1'b0;
        bus.m0_req_i    = 1'b1;
        bus.m0_addr_i   = 32'hC;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold", {31'b0, bus.hold_flag_o}, 32'h1);
            tick();
        end
        bus.ram_ready_i = 1'b1;
        @(negedge clk);
        chk("bp_gnt", {31'b0, bus.m0_gnt_o}, 32'h1);
        tick();
        bus.m0_req_i    = 1'b0;
        bus.ram_ready_i = 1'b0;
        @(negedge clk);
        chk("bp_rvalid", {31'b0, bus.m0_rvalid_o}, 32'h1);
        chk("bp_rdata", bus.m0_rdata_o, 32'h1000_0003);
        tick();
        bus.ram_ready_i = 1'b1;
        tick();

        // Reset asserted on the cycle of a read request.
        bus.m0_req_i  = 1'b1;
        bus.m0_addr_i = 32'h14;
        rst = 1'b1;
        @(negedge clk);
        chk("rr_rst_gnt", {31'b0, bus.m0_gnt_o}, 32'h0);
        tick();
        rst = 1'b0;
        bus.m0_req_i = 1'b0;
        @(negedge clk);
        chk("post_rst_outs", {28'b0, bus.m0_rvalid_o, bus.m1_rvalid_o, bus.ram_req_o, bus.hold_flag_o}, 32'h0);
        tick();

        // Continuous contention for four cycles (fresh after reset).
`ifdef ARB_ROUND_ROBIN_EN
        rr_exp = 4'b1010;   // cycle i -> m1 granted?  bit i
`else
        rr_exp = 4'b1111;
`endif
        bus.m0_req_i  = 1'b1;
        bus.m0_addr_i = 32'h20;
        bus.m1_req_i  = 1'b1;
        bus.m1_addr_i = 32'h24;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("cont4_m1_gnt", {31'b0, bus.m1_gnt_o}, {31'b0, rr_exp[i]});
            tick();
        end
        idle_inputs();
        tick();
        tick();

        run = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
